// File: rtl/mux_row_sequencer.sv
// mux_row_sequencer
// Drives the LED panel row-multiplex lines in the clock_66 domain.
//
// In automatic mode a one-hot row select advances on each column_ready
// pulse and returns to row 0 on position_sync. Break-before-make dead time
// of DEAD_CYCLES cycles, with every row off, separates any two active
// selections. In manual mode the switches drive the select lines.
//
// Interface semantics: column_ready, position_sync and err_clr are
// single-cycle strobes sampled on the rising edge of clock_66. There is no
// back-pressure. A column_ready that lands during dead time cannot be
// honoured. It is dropped and recorded in the sticky overrun_err flag.
//
// Every output is taken directly from a flop. The FSM state register
// (state_q) is a named enum, so an external checker can bind to it.
module mux_row_sequencer #(
    parameter int NB_MUX      = 8,
    parameter int DEAD_CYCLES = 4,
    parameter int IDX_W       = $clog2(NB_MUX)
) (
    input  logic              clock_66,
    input  logic              nrst,
    input  logic              auto_mode,
    input  logic [NB_MUX-1:0] manual_sel,
    input  logic              column_ready,
    input  logic              position_sync,
    input  logic              err_clr,
    output logic [NB_MUX-1:0] mux_out,
    output logic [IDX_W-1:0]  mux_index,
    output logic              frame_start,
    output logic              in_dead,
    output logic              overrun_err
);

    localparam int CNT_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB_MUX - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DEAD   = 2'd1,
        ON     = 2'd2,
        MANUAL = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NB_MUX-1:0]   mux_q, mux_d;
    logic                frame_q, frame_d;
    logic                dead_q, dead_d;
    logic                err_q, err_d;
    logic                mode_q;
    logic                mode_change;

    // Returns the one-hot select for a row index.
    function automatic logic [NB_MUX-1:0] row_onehot(input logic [IDX_W-1:0] idx);
        row_onehot = NB_MUX'(1) << idx;
    endfunction

    // A mode flip goes through dead time, so no row overlaps across modes.
    assign mode_change = (auto_mode != mode_q);

    // Next-state, next-output and sticky error logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        mux_d   = mux_q;
        frame_d = 1'b0;
        err_d   = err_q;

        // A new overrun has priority over a clear in the same cycle.
        if (err_clr) begin
            err_d = 1'b0;
        end
        if ((state_q == DEAD) && column_ready && !position_sync) begin
            err_d = 1'b1;
        end

        if (mode_change) begin
            // A mode change restarts dead time from any state.
            state_d = DEAD;
            cnt_d   = '0;
            mux_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    mux_d = '0;
                    if (column_ready || position_sync) begin
                        idx_d   = '0;
                        cnt_d   = '0;
                        state_d = DEAD;
                    end
                end

                DEAD: begin
                    mux_d = '0;
                    if (position_sync) begin
                        idx_d = '0;
                        cnt_d = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        if (!mode_q) begin
                            state_d = MANUAL;
                            mux_d   = manual_sel;
                        end else begin
                            state_d = ON;
                            mux_d   = row_onehot(idx_q);
                            frame_d = (idx_q == '0);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                ON: begin
                    mux_d = row_onehot(idx_q);
                    if (position_sync) begin
                        // position_sync wins over a simultaneous column_ready.
                        idx_d   = '0;
                        cnt_d   = '0;
                        mux_d   = '0;
                        state_d = DEAD;
                    end else if (column_ready) begin
                        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                        cnt_d   = '0;
                        mux_d   = '0;
                        state_d = DEAD;
                    end
                end

                MANUAL: begin
                    // The switches pass straight through. Strobes are ignored.
                    mux_d = manual_sel;
                end

                default: begin
                    state_d = IDLE;
                    mux_d   = '0;
                end
            endcase
        end

        dead_d = (state_d == DEAD);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clock_66 or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            mux_q   <= '0;
            frame_q <= 1'b0;
            dead_q  <= 1'b0;
            err_q   <= 1'b0;
            mode_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            mux_q   <= mux_d;
            frame_q <= frame_d;
            dead_q  <= dead_d;
            err_q   <= err_d;
            mode_q  <= auto_mode;
        end
    end

    assign mux_out     = mux_q;
    assign mux_index   = idx_q;
    assign frame_start = frame_q;
    assign in_dead     = dead_q;
    assign overrun_err = err_q;

endmodule

// File: tb/tb_mux_row_sequencer.sv
// Testbench for mux_row_sequencer with NB_MUX=8 and DEAD_CYCLES=4.
// A cycle-by-cycle vector table covers the basic sequence and the
// overrun and resync corners. Hand-written sequences cover index wrap,
// the simultaneous strobes case, manual mode and asynchronous reset.
module tb_mux_row_sequencer;

    localparam int NB = 8;
    localparam int DC = 4;

    logic          clock_66;
    logic          nrst;
    logic          auto_mode;
    logic [NB-1:0] manual_sel;
    logic          column_ready;
    logic          position_sync;
    logic          err_clr;
    logic [NB-1:0] mux_out;
    logic [2:0]    mux_index;
    logic          frame_start;
    logic          in_dead;
    logic          overrun_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       cr;
        logic       ps;
        logic       clr;
        logic [7:0] e_mux;
        logic [2:0] e_idx;
        logic       e_fs;
        logic       e_dead;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    mux_row_sequencer #(.NB_MUX(NB), .DEAD_CYCLES(DC)) dut (
        .clock_66      (clock_66),
        .nrst          (nrst),
        .auto_mode     (auto_mode),
        .manual_sel    (manual_sel),
        .column_ready  (column_ready),
        .position_sync (position_sync),
        .err_clr       (err_clr),
        .mux_out       (mux_out),
        .mux_index     (mux_index),
        .frame_start   (frame_start),
        .in_dead       (in_dead),
        .overrun_err   (overrun_err)
    );

    // Clock and watchdog.
    initial clock_66 = 1'b0;
    always #8 clock_66 = ~clock_66;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Advance one active edge, then settle before sampling or driving.
    task automatic tick();
        @(posedge clock_66);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] e_mux, input logic [2:0] e_idx,
                              input logic e_fs, input logic e_dead, input logic e_err);
        check({tag, "_mux"},   32'(mux_out),     32'(e_mux));
        check({tag, "_idx"},   32'(mux_index),   32'(e_idx));
        check({tag, "_frame"}, 32'(frame_start), 32'(e_fs));
        check({tag, "_dead"},  32'(in_dead),     32'(e_dead));
        check({tag, "_err"},   32'(overrun_err), 32'(e_err));
    endtask

    task automatic add_vec(input logic cr, input logic ps, input logic clr, input logic [7:0] e_mux,
                           input logic [2:0] e_idx, input logic e_fs, input logic e_dead,
                           input logic e_err);
        vec_t v;
        v.cr = cr; v.ps = ps; v.clr = clr;
        v.e_mux = e_mux; v.e_idx = e_idx; v.e_fs = e_fs; v.e_dead = e_dead; v.e_err = e_err;
        vecs.push_back(v);
    endtask

    // Pulse column_ready from an active row and expect exp_idx after exactly DC dead cycles.
    task automatic advance(input int exp_idx);
        logic [7:0] row;
        logic [2:0] ei;
        ei  = 3'(exp_idx);
        row = 8'd1 << ei;
        column_ready = 1'b1;
        tick();
        column_ready = 1'b0;
        for (int k = 0; k < DC; k++) begin
            if (k > 0) tick();
            check_outs($sformatf("adv%0d_dead%0d", exp_idx, k), 8'h00, ei, 1'b0, 1'b1, 1'b0);
        end
        tick();
        check_outs($sformatf("adv%0d_on", exp_idx), row, ei, (exp_idx == 0), 1'b0, 1'b0);
        tick();
        check_outs($sformatf("adv%0d_hold", exp_idx), row, ei, 1'b0, 1'b0, 1'b0);
        repeat (10) tick();
    endtask

    initial begin
        nrst          = 1'b1;
        auto_mode     = 1'b1;
        manual_sel    = '0;
        column_ready  = 1'b0;
        position_sync = 1'b0;
        err_clr       = 1'b0;

        // Vector table: cr, ps, clr | mux, idx, frame, dead, err (state after the edge)
        repeat (3) add_vec(0, 0, 0, 8'h00, 3'd0, 0, 0, 0);  // idle
        add_vec(1, 0, 0, 8'h00, 3'd0, 0, 1, 0);             // first pulse -> dead
        repeat (3) add_vec(0, 0, 0, 8'h00, 3'd0, 0, 1, 0);
        add_vec(0, 0, 0, 8'h01, 3'd0, 1, 0, 0);             // row 0 with frame_start
        add_vec(0, 0, 0, 8'h01, 3'd0, 0, 0, 0);
        add_vec(1, 0, 0, 8'h00, 3'd1, 0, 1, 0);             // advance to row 1
        add_vec(0, 0, 0, 8'h00, 3'd1, 0, 1, 0);
        add_vec(1, 0, 0, 8'h00, 3'd1, 0, 1, 1);             // overrun in dead
        add_vec(0, 0, 0, 8'h00, 3'd1, 0, 1, 1);
        add_vec(0, 0, 0, 8'h02, 3'd1, 0, 0, 1);             // row timing unchanged
        add_vec(0, 0, 1, 8'h02, 3'd1, 0, 0, 0);             // err_clr
        add_vec(0, 0, 0, 8'h02, 3'd1, 0, 0, 0);
        add_vec(1, 0, 0, 8'h00, 3'd2, 0, 1, 0);             // advance to row 2
        add_vec(1, 0, 1, 8'h00, 3'd2, 0, 1, 1);             // set beats clear
        add_vec(0, 0, 1, 8'h00, 3'd2, 0, 1, 0);
        add_vec(0, 0, 0, 8'h00, 3'd2, 0, 1, 0);
        add_vec(0, 0, 0, 8'h04, 3'd2, 0, 0, 0);
        add_vec(1, 0, 0, 8'h00, 3'd3, 0, 1, 0);             // advance to row 3
        add_vec(0, 0, 0, 8'h00, 3'd3, 0, 1, 0);
        add_vec(0, 1, 0, 8'h00, 3'd0, 0, 1, 0);             // resync in dead restarts count
        repeat (3) add_vec(0, 0, 0, 8'h00, 3'd0, 0, 1, 0);
        add_vec(0, 0, 0, 8'h01, 3'd0, 1, 0, 0);
        add_vec(0, 0, 0, 8'h01, 3'd0, 0, 0, 0);

        // Reset: asynchronous assertion, then release away from the clock edge.
        #2;
        nrst = 1'b0;
        #30;
        check_outs("reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clock_66);
        nrst = 1'b1;

        foreach (vecs[i]) begin
            column_ready  = vecs[i].cr;
            position_sync = vecs[i].ps;
            err_clr       = vecs[i].clr;
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].e_mux, vecs[i].e_idx,
                       vecs[i].e_fs, vecs[i].e_dead, vecs[i].e_err);
        end
        column_ready  = 1'b0;
        position_sync = 1'b0;
        err_clr       = 1'b0;
        repeat (5) tick();

        // Full sweep 1..7 then wrap to 0 with frame_start.
        for (int r = 1; r <= 8; r++) advance(r % 8);

        // Row 5, then position_sync together with column_ready.
        for (int r = 1; r <= 5; r++) advance(r);
        column_ready  = 1'b1;
        position_sync = 1'b1;
        tick();
        column_ready  = 1'b0;
        position_sync = 1'b0;
        check_outs("both_dead0", 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
        repeat (3) begin
            tick();
            check_outs("both_dead", 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
        end
        tick();
        check_outs("both_on", 8'h01, 3'd0, 1'b1, 1'b0, 1'b0);
        repeat (5) tick();

        // Manual mode round trip from row 3.
        for (int r = 1; r <= 3; r++) advance(r);
        auto_mode  = 1'b0;
        manual_sel = 8'hA5;
        tick();
        check_outs("man_in_dead0", 8'h00, 3'd3, 1'b0, 1'b1, 1'b0);
        repeat (3) begin
            tick();
            check_outs("man_in_dead", 8'h00, 3'd3, 1'b0, 1'b1, 1'b0);
        end
        tick();
        check_outs("man_a5", 8'hA5, 3'd3, 1'b0, 1'b0, 1'b0);
        manual_sel = 8'h0F;
        tick();
        check_outs("man_0f", 8'h0F, 3'd3, 1'b0, 1'b0, 1'b0);
        column_ready = 1'b1;
        tick();
        column_ready = 1'b0;
        check_outs("man_cr_ignored", 8'h0F, 3'd3, 1'b0, 1'b0, 1'b0);
        position_sync = 1'b1;
        tick();
        position_sync = 1'b0;
        check_outs("man_ps_ignored", 8'h0F, 3'd3, 1'b0, 1'b0, 1'b0);
        auto_mode = 1'b1;
        tick();
        check_outs("man_out_dead0", 8'h00, 3'd3, 1'b0, 1'b1, 1'b0);
        repeat (3) begin
            tick();
            check_outs("man_out_dead", 8'h00, 3'd3, 1'b0, 1'b1, 1'b0);
        end
        tick();
        check_outs("man_out_row3", 8'h08, 3'd3, 1'b0, 1'b0, 1'b0);
        repeat (5) tick();

        // Reach row 6 with an overrun pending, then reset asynchronously.
        advance(4);
        advance(5);
        column_ready = 1'b1;
        tick();
        tick();
        column_ready = 1'b0;
        check_outs("r6_overrun", 8'h00, 3'd6, 1'b0, 1'b1, 1'b1);
        repeat (2) tick();
        check_outs("r6_dead_end", 8'h00, 3'd6, 1'b0, 1'b1, 1'b1);
        tick();
        check_outs("r6_on", 8'h40, 3'd6, 1'b0, 1'b0, 1'b1);
        #3;
        nrst = 1'b0;
        #1;
        check_outs("async_reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clock_66);
        @(negedge clock_66);
        nrst = 1'b1;
        repeat (3) begin
            tick();
            check_outs("post_reset_idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        end
        advance(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_row_sequencer.md
Name: mux_row_sequencer

Overview:
Automatic row-multiplexing sequencer for the LED panel. It replaces the static switch-driven multiplex lines on gpio_0 with a one-hot row select that advances on each column_ready pulse from driver_controller, and returns to row 0 on position_sync. It inserts break-before-make dead time between rows and keeps a manual pass-through mode for bench debug, in which the switches drive the select lines. It sits in the clock_66 domain between driver_controller and the multiplex GPIO pins.

Parameters:
NB_MUX, 8, number of multiplexed rows (2..32); width of mux_out.
DEAD_CYCLES, 4, clock_66 cycles with all rows off between any two active selections (>=1).
IDX_W, $clog2(NB_MUX), width of mux_index (derived; do not override).

Ports:
clock_66  in  1  main 66 MHz clock.
nrst  in  1  asynchronous active-low reset.
auto_mode  in  1  1 = automatic sequencing; 0 = manual pass-through.
manual_sel  in  NB_MUX  raw row enables used in manual mode (may be multi-hot).
column_ready  in  1  one-cycle pulse: current row done, advance.
position_sync  in  1  one-cycle pulse: restart the sequence at row 0.
err_clr  in  1  clears overrun_err.
mux_out  out  NB_MUX  row enables, active-high.
mux_index  out  IDX_W  target/active row index in auto mode.
frame_start  out  1  one-cycle pulse when row 0 becomes active.
in_dead  out  1  high while in dead time.
overrun_err  out  1  sticky: column_ready received during dead time.

Behaviour:
- Reset (async, nrst=0): state IDLE, mux_out=0, mux_index=0, frame_start=0, in_dead=0, overrun_err=0, dead counter=0, mode register = 1.
- All outputs are registered. mode_q samples auto_mode each cycle; a change is detected when auto_mode != mode_q.
- States: IDLE, DEAD, ON, MANUAL.
- IDLE (auto): mux_out=0. On column_ready or position_sync: target=0, go to DEAD.
- DEAD: mux_out=0, in_dead=1, counter counts 0..DEAD_CYCLES-1. At the last count: if mode_q=0 go to MANUAL; else go to ON with mux_out=1<<mux_index. frame_start pulses on this same edge when mux_index=0 (auto only).
  - position_sync in DEAD: target=0 and counter restarts at 0.
  - column_ready in DEAD (without position_sync): ignored; overrun_err <= 1.
- ON: mux_out one-hot at mux_index.
  - column_ready: mux_index <= (mux_index==NB_MUX-1) ? 0 : mux_index+1, go to DEAD.
  - position_sync: mux_index <= 0, go to DEAD.
  - Both in the same cycle: position_sync wins (index 0), no error.
- MANUAL: mux_out <= manual_sel, one-cycle latency, no dead time between manual changes. column_ready and position_sync are ignored; mux_index holds.
- Mode change, in any state: go to DEAD with counter=0 (break-before-make). Exiting MANUAL enters auto through DEAD, then ON at the current mux_index.
- Cycle latency in auto mode: column_ready at edge t gives mux_out=0 at t+1 and the new row at t+1+DEAD_CYCLES. Minimum row period is DEAD_CYCLES+1 cycles.
- overrun_err: set has priority over err_clr in the same cycle.
- mux_out is never multi-hot in auto mode. No cycle ever has two different rows on back-to-back, including across mode changes.

Test Plan:
1. Reset, auto_mode=1, NB_MUX=8, DEAD_CYCLES=4, column_ready pulse at cycle 10 -> mux_out=0 for cycles 11-14, mux_out=8'h01 at cycle 15, frame_start high only at 15.
2. Nine column_ready pulses spaced 20 cycles -> rows 0,1,...,7,0 in order. Index wraps from 7 to 0 with a frame_start pulse at the wrap. Exactly 4 zero cycles before each row.
3. In row 5, position_sync and column_ready in the same cycle -> DEAD, then mux_out=8'h01 with mux_index=0 and frame_start; overrun_err stays 0.
4. column_ready two cycles after entering DEAD -> overrun_err=1 and the row sequence is unchanged. err_clr pulse -> overrun_err=0 next cycle.
5. auto_mode 1->0 while row 3 is on, manual_sel=8'hA5 -> 4 zero cycles, then mux_out=8'hA5. Change manual_sel to 8'h0F -> 8'h0F one cycle later. Back to auto -> 4 zero cycles, then 8'h08.
6. Assert nrst low while row 6 is on -> mux_out=0 and overrun_err=0 immediately (async). After release, IDLE with outputs 0 until the next column_ready.
